sequential_subtractor: RTL

SEQUENTIAL_SUBTRACTOR -- requirements
Module: sequential_subtractor

---
 rtl/sub_pkg.sv | 14 +
 rtl/slice_adder.sv | 19 +
 rtl/sequential_subtractor.sv | 134 +++++++++++++
 3 files changed

// File: rtl/sub_pkg.sv
// Shared defaults and state type for the slice-serial subtractor.
package sub_pkg;

    localparam int SUB_WIDTH = 32;
    localparam int SUB_SLICE = 8;
    localparam int NSLICE    = SUB_WIDTH / SUB_SLICE;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

endpackage

// File: rtl/slice_adder.sv
// Combinational SLICE-bit adder with carry-in and carry-out.
module slice_adder
    import sub_pkg::*;
#(
    parameter int SLICE = SUB_SLICE
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    // Full-width add; the extra top bit becomes the slice carry-out.
    always_comb begin
        {cout, sum} = {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, cin};
    end

endmodule

// File: rtl/sequential_subtractor.sv
// Slice-serial subtractor: d = a - b - bin computed as a + ~b + ~bin, one
// SLICE-bit chunk per clock, LSB first, with a valid/ready handshake on
// both sides. bout is the inverted final carry.
module sequential_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH,
    parameter int SLICE = SUB_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int SLICES = WIDTH / SLICE;
    localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    if ((WIDTH % SLICE) != 0) begin : g_width_check
        $error("sequential_subtractor: WIDTH must be a multiple of SLICE");
    end

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] nb_reg;
    logic             carry;
    logic [IDX_W-1:0] idx;

    logic [SLICE-1:0] a_slice;
    logic [SLICE-1:0] nb_slice;
    logic [SLICE-1:0] sum_slice;
    logic             sum_carry;
    logic             last_slice;

    // Select the operand chunk addressed by the slice index.
    always_comb begin
        a_slice    = a_reg[int'(idx) * SLICE +: SLICE];
        nb_slice   = nb_reg[int'(idx) * SLICE +: SLICE];
        last_slice = (idx == LAST_IDX);
    end

    slice_adder #(
        .SLICE (SLICE)
    ) u_slice_adder (
        .x    (a_slice),
        .y    (nb_slice),
        .cin  (carry),
        .sum  (sum_slice),
        .cout (sum_carry)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs decoded from state only.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (last_slice) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: capture operands (b and bin pre-inverted), then fold one
    // slice per cycle into d, carrying between slices through a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg  <= '0;
            nb_reg <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            d      <= '0;
            bout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg  <= a;
                        nb_reg <= ~b;
                        carry  <= ~bin;
                        idx    <= '0;
                    end
                end
                CALC: begin
                    d[int'(idx) * SLICE +: SLICE] <= sum_slice;
                    carry <= sum_carry;
                    idx   <= idx + 1'b1;
                    if (last_slice) begin
                        bout <= ~sum_carry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
